// File: rtl/i2c_bus_sequencer_if.sv
// Command / shifter handshake and pad-mux bus of the I2C master sequencer.
// master: the sequencer itself; slave: the command source, shifters and pad mux.
interface i2c_bus_sequencer_if;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic       cmd_ready;
  logic       cmd_done;
  logic       error;
  logic       busy;
  logic       tx_start;
  logic       tx_done;
  logic       rx_start;
  logic       rx_done;
  logic [1:0] drive_select;
  logic       start_stop_SDA;
  logic       start_stop_SCL;

  modport master (
    input  cmd_valid, cmd, tx_done, rx_done,
    output cmd_ready, cmd_done, error, busy, tx_start, rx_start,
    output drive_select, start_stop_SDA, start_stop_SCL
  );

  modport slave (
    output cmd_valid, cmd, tx_done, rx_done,
    input  cmd_ready, cmd_done, error, busy, tx_start, rx_start,
    input  drive_select, start_stop_SDA, start_stop_SCL
  );
endinterface

// File: rtl/i2c_bus_sequencer.sv
// I2C master bus sequencer: generates START / repeated-START / STOP waveforms,
// selects the SDA/SCL pad source and hands the bus to the TX/RX byte shifters.
// Optional byte watchdog enabled by defining I2C_SEQ_TIMEOUT_EN.
module i2c_bus_sequencer #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input logic                 clk,
  input logic                 n_rst,
  i2c_bus_sequencer_if.master bus
);

  localparam logic [1:0] CmdStart = 2'd0;
  localparam logic [1:0] CmdWrite = 2'd1;
  localparam logic [1:0] CmdRead  = 2'd2;
  localparam logic [1:0] CmdStop  = 2'd3;

  localparam int unsigned    CntW    = $clog2(CLK_DIV + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(CLK_DIV - 1);

  if (CLK_DIV < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("i2c_bus_sequencer: CLK_DIV and TIMEOUT must be >= 1");
  end

  typedef enum logic [3:0] {
    StIdle, StSr, StSa, StSb, StSc, StHold, StTx, StRx, StPa, StPb, StPc
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      drv_q;
  logic            sda_q, scl_q;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            tx_start_q, tx_start_d;
  logic            rx_start_q, rx_start_d;
  logic            busy_q, ready_q;
  logic            accept, phase_done;

  // Pad-mux source and generator levels for each state: {drive_select, SDA, SCL}.
  function automatic logic [3:0] wave(state_e s);
    case (s)
      StIdle:  wave = {2'd0, 1'b1, 1'b1};
      StSr:    wave = {2'd1, 1'b1, 1'b0};
      StSa:    wave = {2'd1, 1'b1, 1'b1};
      StSb:    wave = {2'd1, 1'b0, 1'b1};
      StSc:    wave = {2'd1, 1'b0, 1'b0};
      StHold:  wave = {2'd1, 1'b0, 1'b0};
      StTx:    wave = {2'd3, 1'b0, 1'b0};
      StRx:    wave = {2'd2, 1'b0, 1'b0};
      StPa:    wave = {2'd1, 1'b0, 1'b0};
      StPb:    wave = {2'd1, 1'b0, 1'b1};
      StPc:    wave = {2'd1, 1'b1, 1'b1};
      default: wave = {2'd0, 1'b1, 1'b1};
    endcase
  endfunction

  assign accept     = bus.cmd_valid && ready_q;
  assign phase_done = (cnt_q == '0);

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int unsigned   WdW    = $clog2(TIMEOUT + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

  logic [WdW-1:0] wdog_q;
  logic           abort_q;
  logic           wd_expired;

  assign wd_expired = (wdog_q == WdLast);

  // Byte watchdog plus a flag that suppresses cmd_done for the abort STOP.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wdog_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      if (state_d != state_q) begin
        wdog_q <= '0;
      end else if (state_q == StTx || state_q == StRx) begin
        wdog_q <= wdog_q + WdW'(1);
      end
      if ((state_q == StTx || state_q == StRx) && state_d == StPa) begin
        abort_q <= 1'b1;
      end else if (state_d == StIdle) begin
        abort_q <= 1'b0;
      end
    end
  end
`endif

  // Next state and the one-cycle pulses that accompany each transition.
  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    tx_start_d = 1'b0;
    rx_start_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          case (bus.cmd)
            CmdStart: state_d = StSa;
            CmdStop:  done_d  = 1'b1;
            default:  err_d   = 1'b1;
          endcase
        end
      end
      StSr: if (phase_done) state_d = StSa;
      StSa: if (phase_done) state_d = StSb;
      StSb: if (phase_done) state_d = StSc;
      StSc: begin
        if (phase_done) begin
          state_d = StHold;
          done_d  = 1'b1;
        end
      end
      StHold: begin
        if (accept) begin
          case (bus.cmd)
            CmdWrite: begin
              state_d    = StTx;
              tx_start_d = 1'b1;
            end
            CmdRead: begin
              state_d    = StRx;
              rx_start_d = 1'b1;
            end
            CmdStart: state_d = StSr;
            CmdStop:  state_d = StPa;
            default:  state_d = StHold;
          endcase
        end
      end
      // done is ignored on the start-pulse cycle; the shifter has not begun yet.
      StTx: begin
        if (!tx_start_q && bus.tx_done) begin
          state_d = StHold;
          done_d  = 1'b1;
        end
`ifdef I2C_SEQ_TIMEOUT_EN
        else if (wd_expired) begin
          state_d = StPa;
          err_d   = 1'b1;
        end
`endif
      end
      StRx: begin
        if (!rx_start_q && bus.rx_done) begin
          state_d = StHold;
          done_d  = 1'b1;
        end
`ifdef I2C_SEQ_TIMEOUT_EN
        else if (wd_expired) begin
          state_d = StPa;
          err_d   = 1'b1;
        end
`endif
      end
      StPa: if (phase_done) state_d = StPb;
      StPb: if (phase_done) state_d = StPc;
      StPc: begin
        if (phase_done) begin
          state_d = StIdle;
`ifdef I2C_SEQ_TIMEOUT_EN
          done_d  = !abort_q;
`else
          done_d  = 1'b1;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, phase counter and all outputs registered together so the pad mux
  // source and the waveform levels always switch on the same edge.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      drv_q      <= 2'd0;
      sda_q      <= 1'b1;
      scl_q      <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      tx_start_q <= 1'b0;
      rx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q                <= state_d;
      {drv_q, sda_q, scl_q}  <= wave(state_d);
      done_q                 <= done_d;
      err_q                  <= err_d;
      tx_start_q             <= tx_start_d;
      rx_start_q             <= rx_start_d;
      busy_q                 <= (state_d != StIdle);
      ready_q                <= (state_d == StIdle) || (state_d == StHold);
      if (state_d != state_q) begin
        cnt_q <= CntLoad;
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - CntW'(1);
      end
    end
  end

  assign bus.cmd_ready      = ready_q;
  assign bus.cmd_done       = done_q;
  assign bus.error          = err_q;
  assign bus.busy           = busy_q;
  assign bus.tx_start       = tx_start_q;
  assign bus.rx_start       = rx_start_q;
  assign bus.drive_select   = drv_q;
  assign bus.start_stop_SDA = sda_q;
  assign bus.start_stop_SCL = scl_q;

endmodule

// File: tb/tb_i2c_bus_sequencer.sv
// Directed self-checking bench for i2c_bus_sequencer with CLK_DIV=4.
// Timeout scenario runs only when I2C_SEQ_TIMEOUT_EN is defined (TIMEOUT=16).
module tb_i2c_bus_sequencer;

  localparam int unsigned N = 4;
`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int unsigned TO = 16;
`else
  localparam int unsigned TO = 1024;
`endif

  localparam logic [1:0] START = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic clk;
  logic n_rst;
  int   runs;
  int   fails;

  i2c_bus_sequencer_if bus ();

  i2c_bus_sequencer #(
    .CLK_DIV (N),
    .TIMEOUT (TO)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {drive_select, SDA, SCL, cmd_done, busy}
  logic [5:0] obs;
  assign obs = {bus.drive_select, bus.start_stop_SDA, bus.start_stop_SCL, bus.cmd_done, bus.busy};

  function automatic logic [5:0] ev(input logic [1:0] d, input logic sda, input logic scl,
                                    input logic done, input logic bsy);
    ev = {d, sda, scl, done, bsy};
  endfunction

  // Present a command for exactly one edge; returns just after the accepting edge.
  task automatic issue(input logic [1:0] c);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd       = c;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    runs++;
    if ({obs, bus.cmd_ready, bus.error, bus.tx_start, bus.rx_start}
        !== {ev(2'd0, 1'b1, 1'b1, 1'b0, 1'b0), 4'b1000}) begin
      fails++;
      $display("FAIL reset: got %b want %b", {obs, bus.cmd_ready, bus.error, bus.tx_start,
               bus.rx_start}, {ev(2'd0, 1'b1, 1'b1, 1'b0, 1'b0), 4'b1000});
    end
    n_rst = 1'b1;
  endtask

  task automatic test_idle_stop();
    logic [5:0] exp;
    issue(STOP);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      exp = ev(2'd0, 1'b1, 1'b1, (k == 0), 1'b0);
      runs++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL idle_stop k=%0d: got %b want %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_illegal(input logic [1:0] c);
    logic [8:0] exp;
    issue(c);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      exp = {ev(2'd0, 1'b1, 1'b1, 1'b0, 1'b0), (k == 0), 2'b00};
      runs++;
      if ({obs, bus.error, bus.tx_start, bus.rx_start} !== exp) begin
        fails++;
        $display("FAIL illegal cmd=%0d k=%0d: got %b want %b", c, k,
                 {obs, bus.error, bus.tx_start, bus.rx_start}, exp);
      end
    end
  endtask

  // cmd_done lands on k=3N, i.e. cycle 3N+1 when the accepting cycle is cycle 0.
  task automatic test_start();
    logic [5:0] exp;
    issue(START);
    for (int k = 0; k < 3 * N + 2; k++) begin
      @(negedge clk);
      if (k < N)               exp = ev(2'd1, 1'b1, 1'b1, 1'b0, 1'b1);
      else if (k < 2 * N)      exp = ev(2'd1, 1'b0, 1'b1, 1'b0, 1'b1);
      else if (k < 3 * N)      exp = ev(2'd1, 1'b0, 1'b0, 1'b0, 1'b1);
      else if (k == 3 * N)     exp = ev(2'd1, 1'b0, 1'b0, 1'b1, 1'b1);
      else                     exp = ev(2'd1, 1'b0, 1'b0, 1'b0, 1'b1);
      runs++;
      if ({obs, bus.cmd_ready} !== {exp, (k >= 3 * N)}) begin
        fails++;
        $display("FAIL start k=%0d: got %b want %b", k, {obs, bus.cmd_ready}, {exp, (k >= 3 * N)});
      end
    end
  endtask

  // done is also pulsed on the start-pulse cycle, where it must be ignored.
  task automatic test_transfer(input logic rd);
    logic [5:0] got, exp;
    issue(rd ? READ : WRITE);
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      got = {bus.drive_select, bus.cmd_done, bus.busy, bus.tx_start, bus.rx_start};
      if (k < 20) exp = {(rd ? 2'd2 : 2'd3), 1'b0, 1'b1, (!rd && k == 0), (rd && k == 0)};
      else        exp = {2'd1, (k == 20), 1'b1, 2'b00};
      runs++;
      if (got !== exp) begin
        fails++;
        $display("FAIL transfer rd=%0d k=%0d: got %b want %b", rd, k, got, exp);
      end
      if (rd) bus.rx_done = (k == 0 || k == 19);
      else    bus.tx_done = (k == 0 || k == 19);
    end
  endtask

  task automatic test_done_ignored_in_hold();
    logic [7:0] exp;
    bus.tx_done = 1'b1;
    bus.rx_done = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      exp = {ev(2'd1, 1'b0, 1'b0, 1'b0, 1'b1), 2'b00};
      runs++;
      if ({obs, bus.tx_start, bus.rx_start} !== exp) begin
        fails++;
        $display("FAIL done_in_hold k=%0d: got %b want %b", k, {obs, bus.tx_start, bus.rx_start},
                 exp);
      end
    end
    bus.tx_done = 1'b0;
    bus.rx_done = 1'b0;
  endtask

  task automatic test_repeated_start();
    logic [5:0] exp;
    issue(START);
    for (int k = 0; k < 4 * N + 2; k++) begin
      @(negedge clk);
      if (k < N)           exp = ev(2'd1, 1'b1, 1'b0, 1'b0, 1'b1);
      else if (k < 2 * N)  exp = ev(2'd1, 1'b1, 1'b1, 1'b0, 1'b1);
      else if (k < 3 * N)  exp = ev(2'd1, 1'b0, 1'b1, 1'b0, 1'b1);
      else if (k < 4 * N)  exp = ev(2'd1, 1'b0, 1'b0, 1'b0, 1'b1);
      else                 exp = ev(2'd1, 1'b0, 1'b0, (k == 4 * N), 1'b1);
      runs++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL rstart k=%0d: got %b want %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_stop();
    logic [5:0] exp;
    issue(STOP);
    for (int k = 0; k < 3 * N + 2; k++) begin
      @(negedge clk);
      if (k < N)           exp = ev(2'd1, 1'b0, 1'b0, 1'b0, 1'b1);
      else if (k < 2 * N)  exp = ev(2'd1, 1'b0, 1'b1, 1'b0, 1'b1);
      else if (k < 3 * N)  exp = ev(2'd1, 1'b1, 1'b1, 1'b0, 1'b1);
      else                 exp = ev(2'd0, 1'b1, 1'b1, (k == 3 * N), 1'b0);
      runs++;
      if ({obs, bus.cmd_ready} !== {exp, (k >= 3 * N)}) begin
        fails++;
        $display("FAIL stop k=%0d: got %b want %b", k, {obs, bus.cmd_ready}, {exp, (k >= 3 * N)});
      end
    end
  endtask

  // Reset during SB must release the bus at once and generate no STOP.
  task automatic test_reset_mid();
    logic [5:0] exp;
    exp = ev(2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    issue(START);
    repeat (N + 2) @(negedge clk);
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    runs++;
    if ({obs, bus.cmd_ready} !== {exp, 1'b1}) begin
      fails++;
      $display("FAIL reset_mid: got %b want %b", {obs, bus.cmd_ready}, {exp, 1'b1});
    end
    n_rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      runs++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL reset_mid_idle k=%0d: got %b want %b", k, obs, exp);
      end
    end
  endtask

`ifdef I2C_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    logic [5:0] exp;
    logic [3:0] got_t, exp_t;
    bit         seen;
    issue(START);
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (bus.cmd_done) seen = 1'b1;
    end
    runs++;
    if (!seen) begin
      fails++;
      $display("FAIL timeout_setup: got no cmd_done want cmd_done within 50 cycles");
    end
    issue(WRITE);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      runs++;
      if (k < 16) begin
        got_t = {bus.drive_select, bus.cmd_done, bus.error};
        exp_t = {2'd3, 2'b00};
        if (got_t !== exp_t) begin
          fails++;
          $display("FAIL timeout_tx k=%0d: got %b want %b", k, got_t, exp_t);
        end
      end else begin
        if (k < 20)      exp = ev(2'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        else if (k < 24) exp = ev(2'd1, 1'b0, 1'b1, 1'b0, 1'b1);
        else if (k < 28) exp = ev(2'd1, 1'b1, 1'b1, 1'b0, 1'b1);
        else             exp = ev(2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        if ({obs, bus.error} !== {exp, (k == 16)}) begin
          fails++;
          $display("FAIL timeout_stop k=%0d: got %b want %b", k, {obs, bus.error},
                   {exp, (k == 16)});
        end
      end
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    runs          = 0;
    fails         = 0;
    n_rst         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd       = 2'd0;
    bus.tx_done   = 1'b0;
    bus.rx_done   = 1'b0;
    test_reset();
    test_idle_stop();
    test_illegal(WRITE);
    test_illegal(READ);
    test_start();
    test_transfer(1'b0);
    test_transfer(1'b1);
    test_done_ignored_in_hold();
    test_repeated_start();
    test_stop();
    test_reset_mid();
`ifdef I2C_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", runs, fails);
    $finish;
  end

endmodule
